wb_ahb_bridge: RTL and testbench
================================

WB_AHB_BRIDGE -- requirements
Module: wb_ahb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum HREADY-low wait cycles in the data phase before abort (legal range 1..65535).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on error or timeout.
REQ-003 SHALL be clocked by HCLK, a single clock; reset is asynchronous and active-low (HRESETn).
REQ-004 SHALL have ports (name, direction, width, meaning):
- HCLK, input, 1: clock.
- HRESETn, input, 1: async active-low reset.
- wbs_cyc_i, input, 1: WB cycle.
- wbs_stb_i, input, 1: WB strobe.
- wbs_we_i, input, 1: WB write.
- wbs_sel_i, input, 4: WB byte select.
- wbs_adr_i, input, 32: WB address.
- wbs_dat_i, input, 32: WB write data.
- wbs_ack_o, output, 1: WB ack.
- wbs_dat_o, output, 32: WB read data.
- HADDR, output, 32: AHB address.
- HTRANS, output, 2: AHB transfer type.
- HWRITE, output, 1: AHB write.
- HSIZE, output, 3: AHB size.
- HWDATA, output, 32: AHB write data.
- HRDATA, input, 32: AHB read data.
- HREADY, input, 1: AHB ready.
- HRESP, input, 1: AHB response (1 = ERROR).
- err_o, output, 1: sticky error flag.
- tmo_o, output, 1: sticky timeout flag.
- flag_clr_i, input, 1: clears err_o and tmo_o.

Function
REQ-005 SHALL implement the FSM IDLE -> ADDR -> DATA -> ACK -> IDLE, with exactly one AHB transfer per Wishbone request.
REQ-006 In IDLE, wbs_cyc_i&wbs_stb_i high SHALL latch adr/we/sel/dat_i and move to ADDR the next cycle.
REQ-007 In ADDR, SHALL drive HTRANS=2'b10 (NONSEQ) plus HADDR/HWRITE/HSIZE, and advance to DATA when HREADY=1; in every other state HTRANS SHALL be 2'b00.
REQ-008 SHALL map sel to HSIZE/HADDR[1:0] as follows:
- 1111 -> word, HADDR[1:0]=00.
- 0011 -> half, 00; 1100 -> half, 10.
- 0001 -> byte, 00; 0010 -> byte, 01; 0100 -> byte, 10; 1000 -> byte, 11.
- Any other pattern -> word, HADDR[1:0]=00.
- HADDR[31:2] = wbs_adr_i[31:2] in all cases.
REQ-009 In DATA, SHALL hold HWDATA = latched write data (unshifted WB lanes); HWDATA SHALL be 0 outside DATA.
REQ-010 In DATA with HREADY=1 and HRESP=0, SHALL capture HRDATA into wbs_dat_o (reads only) and go to ACK.
REQ-011 HRESP=1 in DATA (either cycle of the two-cycle error response) SHALL set err_o, load ERR_DATA into wbs_dat_o for reads, and go to ACK once HREADY=1.
REQ-012 SHALL count consecutive HREADY-low cycles in DATA; on reaching TIMEOUT it SHALL set tmo_o, load ERR_DATA into wbs_dat_o, and go to ACK without waiting further.
REQ-013 In ACK, SHALL assert wbs_ack_o for exactly one cycle and then return to IDLE; wbs_ack_o SHALL be 0 in all other states.
REQ-014 Back-to-back: stb still high in the cycle after ACK SHALL be treated as a new request, giving minimum latency stb->ack of 4 cycles with zero wait states.
REQ-015 wbs_dat_o SHALL hold its last value until the next read completion; write completions SHALL leave it unchanged.
REQ-016 cyc/stb dropping mid-transfer SHALL NOT abort the transfer; the bridge SHALL finish the AHB transfer and still pulse ack.
REQ-017 flag_clr_i SHALL clear both flags on the next edge; a same-cycle set SHALL take priority over clear.

Reset
REQ-018 On HRESETn low, SHALL go asynchronously to IDLE with HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, wbs_ack_o=0, wbs_dat_o=0, err_o=0, tmo_o=0, and the timeout counter at 0.
REQ-019 Reset asserted mid-transfer SHALL abandon the transfer with no ack, and the bridge SHALL accept a new request on the first cycle after release.

Verification
REQ-020 Word write adr=0x3000_0004, dat=0x1234_5678, sel=1111, HREADY=1 -> NONSEQ at HADDR 0x3000_0004, HSIZE=010, HWRITE=1; HWDATA=0x1234_5678 next cycle; ack 4 cycles after stb.
REQ-021 Byte read sel=0100, adr=0x3000_0010, HRDATA=0x00AB_0000 -> HADDR=0x3000_0012, HSIZE=000, wbs_dat_o=0x00AB_0000 at ack.
REQ-022 Read with HREADY low for 3 data cycles -> ack delayed by 3 cycles; tmo_o stays 0.
REQ-023 HRESP=1 two-cycle error on read -> err_o=1, wbs_dat_o=0xDEAD_BEEF, single ack; flag_clr_i pulse -> err_o=0.
REQ-024 TIMEOUT=4 with HREADY held low -> ack 4 data cycles in, tmo_o=1, HTRANS=00 after ADDR.
REQ-025 HRESETn low during DATA -> all outputs at reset values immediately, no ack; a request after release completes normally.

Source files
------------

// File: rtl/wb_ahb_bridge_if.sv
// Wishbone slave / AHB-Lite master signal bundle for wb_ahb_bridge.
// The bridge takes the slave modport; the bus side (WB master + AHB slave) takes master.
interface wb_ahb_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        err_o;
  logic        tmo_o;
  logic        flag_clr_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP,
    output err_o, tmo_o,
    input  flag_clr_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP,
    input  err_o, tmo_o,
    output flag_clr_i
  );
endinterface

// File: rtl/wb_ahb_bridge.sv
// Single-transfer Wishbone-to-AHB-Lite bridge: one NONSEQ per WB request,
// with error/timeout capture into sticky flags and a fixed error read value.
module wb_ahb_bridge #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input logic           HCLK,
  input logic           HRESETn,
  wb_ahb_bridge_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] ACK  = 2'd3;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic [31:0] haddr_q, wdat_q, rdat_q;
  logic [2:0]  hsize_q;
  logic        hwrite_q, err_q, tmo_q;
  logic [2:0]  size_d;
  logic [1:0]  lsb_d;
  logic        err_set, tmo_hit;
  logic        unused_adr;

  assign unused_adr = &{1'b0, bus.wbs_adr_i[1:0]};

  // Lane select -> transfer size and low address bits; odd patterns fall back to a word.
  always_comb begin
    size_d = 3'b010;
    lsb_d  = 2'b00;
    case (bus.wbs_sel_i)
      4'b0011: size_d = 3'b001;
      4'b1100: begin size_d = 3'b001; lsb_d = 2'b10; end
      4'b0001: size_d = 3'b000;
      4'b0010: begin size_d = 3'b000; lsb_d = 2'b01; end
      4'b0100: begin size_d = 3'b000; lsb_d = 2'b10; end
      4'b1000: begin size_d = 3'b000; lsb_d = 2'b11; end
      default: ;
    endcase
  end

  assign err_set = (state == DATA) && bus.HRESP;
  assign tmo_hit = (state == DATA) && !bus.HREADY && (wait_cnt == TMO_LAST);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      haddr_q  <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          haddr_q  <= {bus.wbs_adr_i[31:2], lsb_d};
          hsize_q  <= size_d;
          hwrite_q <= bus.wbs_we_i;
          wdat_q   <= bus.wbs_dat_i;
          state    <= ADDR;
        end
        ADDR: begin
          wait_cnt <= '0;
          if (bus.HREADY) state <= DATA;
        end
        DATA: begin
          if (bus.HREADY) begin
            if (!hwrite_q) rdat_q <= bus.HRESP ? ERR_DATA : bus.HRDATA;
            state <= ACK;
          end else if (tmo_hit) begin
            if (!hwrite_q) rdat_q <= ERR_DATA;
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      if (err_set)             err_q <= 1'b1;
      else if (bus.flag_clr_i) err_q <= 1'b0;
      if (tmo_hit)             tmo_q <= 1'b1;
      else if (bus.flag_clr_i) tmo_q <= 1'b0;
    end
  end

  assign bus.HTRANS    = (state == ADDR) ? 2'b10 : 2'b00;
  assign bus.HADDR     = haddr_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HWDATA    = (state == DATA) ? wdat_q : 32'h0;
  assign bus.wbs_ack_o = (state == ACK);
  assign bus.wbs_dat_o = rdat_q;
  assign bus.err_o     = err_q;
  assign bus.tmo_o     = tmo_q;
endmodule

// File: tb/tb_wb_ahb_bridge.sv
// Directed bench for wb_ahb_bridge: table of single transfers plus hand-written
// back-to-back, early stb drop, flag clear/priority and mid-transfer reset sequences.
module tb_wb_ahb_bridge;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int checks = 0;
  int errors = 0;

  wb_ahb_bridge_if bus();
  wb_ahb_bridge #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          waits;
    logic        resp_err;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_dat;
    int          exp_cyc;
    logic        exp_err;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Caller sits in the stb cycle (1 ns after an edge); returns in the cycle after ack.
  task automatic xfer(input vec_t v, input bit keep, input bit drop, input string nm);
    int ncyc;
    bit got_ack;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = v.we;
    bus.wbs_sel_i = v.sel; bus.wbs_adr_i = v.adr; bus.wbs_dat_i = v.wdat;
    bus.HRDATA = v.rdat; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    ncyc = 1;
    got_ack = 1'b0;
    check({nm, " idle htrans"}, {30'd0, bus.HTRANS}, 32'h0);
    tick(); ncyc++;
    check({nm, " addr htrans"}, {30'd0, bus.HTRANS}, 32'h2);
    check({nm, " haddr"}, bus.HADDR, v.exp_haddr);
    check({nm, " hsize"}, {29'd0, bus.HSIZE}, {29'd0, v.exp_hsize});
    check({nm, " hwrite"}, {31'd0, bus.HWRITE}, {31'd0, v.we});
    if (drop) begin bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; end
    for (int d = 0; d < 20; d++) begin
      tick(); ncyc++;
      if (bus.wbs_ack_o) begin got_ack = 1'b1; break; end
      bus.HREADY = (d >= v.waits);
      bus.HRESP  = v.resp_err && (d >= v.waits - 1);
      check({nm, " data htrans"}, {30'd0, bus.HTRANS}, 32'h0);
      if (d == 0) check({nm, " hwdata"}, bus.HWDATA, v.we ? v.wdat : 32'h0);
    end
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    check({nm, " ack seen"}, {31'd0, got_ack}, 32'h1);
    check({nm, " latency"}, ncyc, v.exp_cyc);
    check({nm, " dat_o"}, bus.wbs_dat_o, v.exp_dat);
    check({nm, " err_o"}, {31'd0, bus.err_o}, {31'd0, v.exp_err});
    check({nm, " tmo_o"}, {31'd0, bus.tmo_o}, {31'd0, v.exp_tmo});
    check({nm, " ack htrans"}, {30'd0, bus.HTRANS}, 32'h0);
    if (!keep) begin bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; end
    tick();
    check({nm, " ack one cycle"}, {31'd0, bus.wbs_ack_o}, 32'h0);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, " htrans"}, {30'd0, bus.HTRANS}, 32'h0);
    check({nm, " haddr"}, bus.HADDR, 32'h0);
    check({nm, " hwrite"}, {31'd0, bus.HWRITE}, 32'h0);
    check({nm, " hsize"}, {29'd0, bus.HSIZE}, 32'h0);
    check({nm, " hwdata"}, bus.HWDATA, 32'h0);
    check({nm, " ack"}, {31'd0, bus.wbs_ack_o}, 32'h0);
    check({nm, " dat_o"}, bus.wbs_dat_o, 32'h0);
    check({nm, " err"}, {31'd0, bus.err_o}, 32'h0);
    check({nm, " tmo"}, {31'd0, bus.tmo_o}, 32'h0);
  endtask

  initial begin
    //         we    sel      adr            wdat           rdat          wt  re    haddr          sz     dat           cyc err   tmo
    vecs[0] = '{1'b1, 4'b1111, 32'h3000_0004, 32'h1234_5678, 32'h0,        0, 1'b0, 32'h3000_0004, 3'd2, 32'h0000_0000, 4, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'b0100, 32'h3000_0010, 32'h0,         32'h00AB_0000, 0, 1'b0, 32'h3000_0012, 3'd0, 32'h00AB_0000, 4, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'b1100, 32'h3000_0020, 32'h0,         32'hCAFE_0000, 0, 1'b0, 32'h3000_0022, 3'd1, 32'hCAFE_0000, 4, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'b0010, 32'h4000_0103, 32'h0000_5500, 32'h5555_5555, 0, 1'b0, 32'h4000_0101, 3'd0, 32'hCAFE_0000, 4, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'b1000, 32'h0000_0000, 32'h0,         32'hAA00_0000, 0, 1'b0, 32'h0000_0003, 3'd0, 32'hAA00_0000, 4, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4'b0101, 32'h5000_0007, 32'h0,         32'h1111_2222, 0, 1'b0, 32'h5000_0004, 3'd2, 32'h1111_2222, 4, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 4'b1111, 32'h6000_0000, 32'h0,         32'h8765_4321, 3, 1'b0, 32'h6000_0000, 3'd2, 32'h8765_4321, 7, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'b0011, 32'h6000_0002, 32'h0,         32'h0000_BEEF, 0, 1'b0, 32'h6000_0000, 3'd1, 32'h0000_BEEF, 4, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 4'b1111, 32'h7000_0000, 32'h0,         32'h0000_1234, 1, 1'b1, 32'h7000_0000, 3'd2, 32'hDEAD_BEEF, 5, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 4'b0001, 32'h7000_0101, 32'h0,         32'h0000_0077, 100, 1'b0, 32'h7000_0100, 3'd0, 32'hDEAD_BEEF, 7, 1'b1, 1'b1};

    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    bus.HRDATA = 32'h0; bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.flag_clr_i = 1'b0;

    #12;
    check_reset_vals("reset");
    tick(); HRESETn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) xfer(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    // Clear pulse drops both sticky flags on the next edge.
    bus.flag_clr_i = 1'b1; tick(); bus.flag_clr_i = 1'b0;
    check("clr err", {31'd0, bus.err_o}, 32'h0);
    check("clr tmo", {31'd0, bus.tmo_o}, 32'h0);

    // Error set while clear is held: set wins, then clear takes effect after.
    bus.flag_clr_i = 1'b1;
    xfer(vecs[8], 1'b0, 1'b0, "set_over_clr");
    bus.flag_clr_i = 1'b0;
    check("set_over_clr after", {31'd0, bus.err_o}, 32'h0);

    // Back-to-back: stb stays high after ack, next request starts immediately.
    xfer(vecs[1], 1'b1, 1'b0, "b2b_a");
    xfer(vecs[7], 1'b0, 1'b0, "b2b_b");

    // stb dropped after the address phase still completes with an ack.
    xfer(vecs[2], 1'b0, 1'b1, "drop_stb");

    // Reset during a waited data phase.
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h8000_0008; bus.wbs_dat_i = 32'hA5A5_5A5A;
    tick();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    tick();
    bus.HREADY = 1'b0;
    check("rst pre hwdata", bus.HWDATA, 32'hA5A5_5A5A);
    #2 HRESETn = 1'b0;
    #1;
    check_reset_vals("rst mid");
    tick(); tick();
    check("rst no ack", {31'd0, bus.wbs_ack_o}, 32'h0);
    #2 HRESETn = 1'b1;
    tick();
    vecs[1].exp_dat = 32'h00AB_0000;
    xfer(vecs[1], 1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
